// File: rtl/alu_iter.sv
// alu_iter: handshaked multi-cycle ALU for the WISC-SP13 execute stage.
// Shifts and rotates run one bit per cycle through a single working
// register. Every other op is evaluated as the request is accepted and
// presented on the following cycle.
module alu_iter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] pc,
    input  logic [7:0]       imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Shift/rotate selector, shared by the immediate and register forms.
    localparam logic [1:0] M_ROL = 2'b00;
    localparam logic [1:0] M_SLL = 2'b01;
    localparam logic [1:0] M_ROR = 2'b10;
    localparam logic [1:0] M_SRL = 2'b11;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work;      // result / shift working register
    logic [SHAMT_W-1:0] cnt;       // shift steps remaining
    logic [1:0]         mode;      // captured shift selector
    logic               ill_q;

    logic               is_shift;
    logic [SHAMT_W-1:0] amt;
    logic [1:0]         smode;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ill;
    logic [WIDTH-1:0]   simm5, zimm5, simm8;
    logic [WIDTH-1:0]   rev;
    logic [WIDTH:0]     sum17;
    logic [WIDTH-1:0]   step;

    assign simm5 = {{(WIDTH-5){imm[4]}}, imm[4:0]};
    assign zimm5 = {{(WIDTH-5){1'b0}}, imm[4:0]};
    assign simm8 = {{(WIDTH-8){imm[7]}}, imm};
    assign sum17 = {1'b0, rs} + {1'b0, rt};

    // Shift-class decode: immediate forms 101xx take imm, register form 11010 takes rt.
    always_comb begin
        is_shift = 1'b0;
        amt      = '0;
        smode    = M_ROL;
        if (op[4:2] == 3'b101) begin
            is_shift = 1'b1;
            amt      = imm[SHAMT_W-1:0];
            smode    = op[1:0];
        end else if (op == 5'b11010) begin
            is_shift = 1'b1;
            amt      = rt[SHAMT_W-1:0];
            smode    = funct;
        end
    end

    // Bit reverse of rs for BTR.
    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev[i] = rs[WIDTH-1-i];
        end
    end

    // Single-cycle ops, evaluated on the live inputs at the acceptance edge.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            5'b01000: alu_res = simm5 - rs;
            5'b01001: alu_res = rs + simm5;
            5'b01010: alu_res = rs & ~zimm5;
            5'b01011: alu_res = rs ^ zimm5;
            5'b10000,
            5'b10001,
            5'b10011: alu_res = rs + simm5;
            5'b10010: alu_res = {rs[7:0], imm};
            5'b11000: alu_res = simm8;
            5'b11001: alu_res = rev;
            5'b11011: begin
                case (funct)
                    2'b00:   alu_res = rs + rt;
                    2'b01:   alu_res = rt - rs;
                    2'b10:   alu_res = rs ^ rt;
                    default: alu_res = rs & ~rt;
                endcase
            end
            5'b11100: alu_res = {{(WIDTH-1){1'b0}}, (rs == rt)};
            5'b11101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs) <  $signed(rt))};
            5'b11110: alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs) <= $signed(rt))};
            5'b11111: alu_res = {{(WIDTH-1){1'b0}}, sum17[WIDTH]};
            5'b01100: alu_res = {{(WIDTH-1){1'b0}}, (rs != '0)};
            5'b01101: alu_res = {{(WIDTH-1){1'b0}}, (rs == '0)};
            5'b01110: alu_res = {{(WIDTH-1){1'b0}}, rs[WIDTH-1]};
            5'b01111: alu_res = {{(WIDTH-1){1'b0}}, ~rs[WIDTH-1]};
            5'b00110,
            5'b00111: alu_res = pc;
            5'b10100, 5'b10101, 5'b10110, 5'b10111,
            5'b11010: alu_res = rs;   // shift class, handled by the iterator
            default: begin
                alu_res = '0;
                alu_ill = 1'b1;
            end
        endcase
    end

    // One shift/rotate step of the working register.
    always_comb begin
        case (mode)
            M_ROL:   step = {work[WIDTH-2:0], work[WIDTH-1]};
            M_SLL:   step = {work[WIDTH-2:0], 1'b0};
            M_ROR:   step = {work[0], work[WIDTH-1:1]};
            default: step = {1'b0, work[WIDTH-1:1]};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; a zero shift amount skips SHIFT.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_shift && (amt != '0)) state_nxt = SHIFT;
                    else                         state_nxt = DONE;
                end
            end
            SHIFT: begin
                if (cnt == SHAMT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load at acceptance, iterate in SHIFT, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            cnt   <= '0;
            mode  <= M_ROL;
            ill_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_shift) begin
                            work  <= rs;
                            cnt   <= amt;
                            mode  <= smode;
                            ill_q <= 1'b0;
                        end else begin
                            work  <= alu_res;
                            cnt   <= '0;
                            ill_q <= alu_ill;
                        end
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - SHAMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign res     = work;
    assign illegal = ill_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: the driver queues the expected result and
// first-valid cycle for each request; a negedge monitor pops and compares.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [1:0]  funct = '0;
    logic [15:0] rs = '0, rt = '0, pc = '0;
    logic [7:0]  imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] res;
    logic        illegal;

    typedef struct {
        logic [15:0] res;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   seen = 1'b0;

    alu_iter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct(funct), .rs(rs), .rt(rt), .pc(pc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: compare on the first cycle each response is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res", {16'h0, res}, {16'h0, e.res});
                chk("illegal", {31'h0, illegal}, {31'h0, e.ill});
                chk("latency_cycle", cyc, e.cyc);
            end
        end
        if (!out_valid || out_ready) seen = 1'b0;
    end

    // Drive one request once in_ready is seen; k is the expected shift step count.
    task automatic send(input logic [4:0] o, input logic [1:0] f,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] p, input logic [7:0] i,
                        input logic [15:0] er, input logic ei,
                        input int k, input bit push);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        op = o; funct = f; rs = a; rt = b; pc = p; imm = i;
        in_valid = 1'b1;
        if (push) exp_q.push_back('{er, ei, cyc + 1 + k});
        @(posedge clk);
        #1 in_valid = 1'b0;
        rs = 16'hDEAD; rt = 16'hBEEF; imm = 8'h5A;  // late operand changes must be ignored
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] held;
        bit          fired;
        int          t;

        // Reset state
        #12;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_res", {16'h0, res}, 32'd0);
        chk("rst_illegal", {31'h0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   op        funct  rs        rt        pc        imm     exp      ill  k
        send(5'b11011, 2'b00, 16'h7FFF, 16'h0001, 16'h0000, 8'h00, 16'h8000, 0, 0, 1); // ADD
        send(5'b11111, 2'b00, 16'h7FFF, 16'h0001, 16'h0000, 8'h00, 16'h0000, 0, 0, 1); // SCO
        send(5'b11111, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 8'h00, 16'h0001, 0, 0, 1); // SCO
        send(5'b10100, 2'b00, 16'h8001, 16'h0000, 16'h0000, 8'h04, 16'h0018, 0, 4, 1); // ROLI 4
        send(5'b10110, 2'b00, 16'h0001, 16'h0000, 16'h0000, 8'h0F, 16'h0002, 0, 15, 1); // RORI 15
        send(5'b10111, 2'b00, 16'h8000, 16'h0000, 16'h0000, 8'h00, 16'h8000, 0, 0, 1); // SRLI 0
        send(5'b11010, 2'b01, 16'h0003, 16'h0002, 16'h0000, 8'h00, 16'h000C, 0, 2, 1); // SLL reg 2
        send(5'b11101, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 8'h00, 16'h0001, 0, 0, 1); // SLT
        send(5'b11110, 2'b00, 16'h1234, 16'h1234, 16'h0000, 8'h00, 16'h0001, 0, 0, 1); // SLE
        send(5'b01110, 2'b00, 16'h8000, 16'h0000, 16'h0000, 8'h00, 16'h0001, 0, 0, 1); // BLTZ
        send(5'b01111, 2'b00, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0001, 0, 0, 1); // BGEZ
        send(5'b11011, 2'b01, 16'h0003, 16'h000A, 16'h0000, 8'h00, 16'h0007, 0, 0, 1); // SUB
        send(5'b00000, 2'b00, 16'h1111, 16'h2222, 16'h0000, 8'h00, 16'h0000, 1, 0, 1); // illegal
        send(5'b10010, 2'b00, 16'h12AB, 16'h0000, 16'h0000, 8'hCD, 16'hABCD, 0, 0, 1); // SLBI
        send(5'b11001, 2'b00, 16'h0001, 16'h0000, 16'h0000, 8'h00, 16'h8000, 0, 0, 1); // BTR
        send(5'b01000, 2'b00, 16'h0001, 16'h0000, 16'h0000, 8'h1F, 16'hFFFE, 0, 0, 1); // SUBI
        send(5'b00110, 2'b00, 16'h0000, 16'h0000, 16'h1234, 8'h00, 16'h1234, 0, 0, 1); // JAL
        send(5'b01010, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 8'h0F, 16'hFFF0, 0, 0, 1); // ANDNI
        drain();

        // Backpressure: stall 4 cycles with a spurious request in the middle
        out_ready = 1'b0;
        send(5'b11011, 2'b10, 16'h00FF, 16'h0F0F, 16'h0000, 8'h00, 16'h0FF0, 0, 0, 1); // XOR
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        held = res;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'h0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
            chk("stall_res_stable", {16'h0, res}, {16'h0, held});
            if (i == 1) begin
                op = 5'b11000; imm = 8'h11; in_valid = 1'b1;
            end
            if (i == 2) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_out_valid", {31'h0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'h0, in_ready}, 32'd1);
        send(5'b11000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 8'h7F, 16'h007F, 0, 0, 1); // LBI
        drain();
        chk("spurious_dropped", exp_q.size(), 32'd0);

        // Reset in the middle of SRL by 12
        send(5'b11010, 2'b11, 16'hF0F0, 16'h000C, 16'h0000, 8'h00, 16'h0000, 0, 12, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("midrst_res", {16'h0, res}, 32'd0);
        chk("midrst_illegal", {31'h0, illegal}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fired = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (out_valid) fired = 1'b1;
        end
        chk("aborted_no_valid", {31'h0, fired}, 32'd0);
        send(5'b11000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 8'h80, 16'hFF80, 0, 0, 1); // LBI
        drain();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
